// File: rtl/div_pkg.sv
// Shared types and latency constants for the sequential divider.
package div_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    NEG  = 3'd1,
    CALC = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } div_state_t;

  // Special-case path: NEG -> FIX -> DONE, counted from the accept edge.
  localparam int DIV_FIX_CYCLES = 3;

  // Normal path: NEG, WIDTH CALC steps, FIX -> DONE.
  function automatic int DIV_LAT(input int w);
    return w + 3;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract step: shift the next dividend bit into the
// partial remainder, subtract the divisor if it fits, emit one quotient bit.
module div_step #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH:0]   rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH:0]   rem_nxt,
  output logic [WIDTH-1:0] quo_nxt
);

  logic [WIDTH:0] sh;
  logic [WIDTH:0] sub;
  logic           ge;

  // Compare on the full widened value so the restore decision never
  // depends on a wrapped subtraction; the remainder itself fits WIDTH+1.
  always_comb begin
    sh      = {rem[WIDTH-1:0], quo[WIDTH-1]};
    ge      = ({rem, quo[WIDTH-1]} >= {2'b00, dvs});
    sub     = sh - {1'b0, dvs};
    rem_nxt = ge ? sub : sh;
    quo_nxt = {quo[WIDTH-2:0], ge};
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider, signed/unsigned, one quotient bit per cycle.
// Handshake: request on valid_in/ready_in, result on valid_out/ready_out.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  output logic             ready_in,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow,
  output logic             valid_out,
  input  logic             ready_out
);

  if (WIDTH < 4 || WIDTH > 64) begin : g_bad_width
    $error("seq_divider: WIDTH must be in 4..64");
  end

  localparam int               CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] SMIN  = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_q;      // original dividend, kept for div-by-zero
  logic [WIDTH-1:0] b_q;      // original divisor
  logic             sm_q;
  logic [WIDTH-1:0] mag_b;    // |divisor| used by the step
  logic [WIDTH:0]   rem_q;    // partial remainder
  logic [WIDTH-1:0] quo_q;    // |dividend| shifting out, quotient shifting in
  logic             q_neg, r_neg, dbz, ovf;

  logic [WIDTH:0]   rem_nxt;
  logic [WIDTH-1:0] quo_nxt;

  logic a_sgn, b_sgn;
  assign a_sgn = sm_q & a_q[WIDTH-1];
  assign b_sgn = sm_q & b_q[WIDTH-1];

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem     (rem_q),
    .quo     (quo_q),
    .dvs     (mag_b),
    .rem_nxt (rem_nxt),
    .quo_nxt (quo_nxt)
  );

  // Control FSM; every datapath register loads only in its owning state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      ready_in    <= 1'b1;
      valid_out   <= 1'b0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      a_q         <= '0;
      b_q         <= '0;
      sm_q        <= 1'b0;
      mag_b       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      dbz         <= 1'b0;
      ovf         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (valid_in) begin
            a_q      <= dividend;
            b_q      <= divisor;
            sm_q     <= signed_mode;
            ready_in <= 1'b0;
            state    <= NEG;
          end
        end
        NEG: begin
          // MIN's magnitude is representable as unsigned, so no extra bit.
          quo_q <= a_sgn ? -a_q : a_q;
          mag_b <= b_sgn ? -b_q : b_q;
          rem_q <= '0;
          cnt   <= '0;
          q_neg <= a_sgn ^ b_sgn;
          r_neg <= a_sgn;
          dbz   <= (b_q == '0);
          ovf   <= sm_q && (a_q == SMIN) && (b_q == '1);
          if ((b_q == '0) || (sm_q && (a_q == SMIN) && (b_q == '1)))
            state <= FIX;
          else
            state <= CALC;
        end
        CALC: begin
          rem_q <= rem_nxt;
          quo_q <= quo_nxt;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) state <= FIX;
        end
        FIX: begin
          div_by_zero <= dbz;
          overflow    <= ovf;
          if (dbz) begin
            quotient  <= '1;
            remainder <= a_q;
          end else if (ovf) begin
            quotient  <= a_q;
            remainder <= '0;
          end else begin
            quotient  <= q_neg ? -quo_q : quo_q;
            remainder <= r_neg ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
          end
          valid_out <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          // Results hold until drained; accept resumes a cycle later.
          if (ready_out) begin
            valid_out <= 1'b0;
            ready_in  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          ready_in  <= 1'b1;
          valid_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: a WIDTH=64 and a WIDTH=8 instance.
module tb_seq_divider;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        vi_64 = 0, sm_64 = 0, ro_64 = 0;
  logic [63:0] a_64 = '0, b_64 = '0;
  logic        ri_64, dz_64, ov_64, vo_64;
  logic [63:0] q_64, r_64;

  logic        vi_8 = 0, sm_8 = 0, ro_8 = 0;
  logic [7:0]  a_8 = '0, b_8 = '0;
  logic        ri_8, dz_8, ov_8, vo_8;
  logic [7:0]  q_8, r_8;

  seq_divider #(.WIDTH(64)) u_dut64 (
    .clk(clk), .rst(rst), .valid_in(vi_64), .ready_in(ri_64),
    .signed_mode(sm_64), .dividend(a_64), .divisor(b_64),
    .quotient(q_64), .remainder(r_64), .div_by_zero(dz_64),
    .overflow(ov_64), .valid_out(vo_64), .ready_out(ro_64)
  );

  seq_divider #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .valid_in(vi_8), .ready_in(ri_8),
    .signed_mode(sm_8), .dividend(a_8), .divisor(b_8),
    .quotient(q_8), .remainder(r_8), .div_by_zero(dz_8),
    .overflow(ov_8), .valid_out(vo_8), .ready_out(ro_8)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // fl = {ready_in, valid_out, div_by_zero, overflow}
  task automatic peek(input bit is8, output logic [63:0] q, output logic [63:0] r,
                      output logic [3:0] fl);
    if (is8) begin
      q = {56'b0, q_8}; r = {56'b0, r_8}; fl = {ri_8, vo_8, dz_8, ov_8};
    end else begin
      q = q_64; r = r_64; fl = {ri_64, vo_64, dz_64, ov_64};
    end
  endtask

  // Present one request, then scramble operands to show they were latched.
  task automatic start(input bit is8, input bit sm, input logic [63:0] a,
                       input logic [63:0] b, input string tag);
    logic [63:0] q, r;
    logic [3:0]  fl;
    @(negedge clk);
    peek(is8, q, r, fl);
    chk({tag, " ready_in"}, {63'b0, fl[3]}, 64'd1);
    if (is8) begin vi_8 = 1; sm_8 = sm; a_8 = a[7:0]; b_8 = b[7:0]; end
    else     begin vi_64 = 1; sm_64 = sm; a_64 = a; b_64 = b; end
    @(posedge clk); #1;
    if (is8) begin vi_8 = 0; sm_8 = ~sm; a_8 = ~a[7:0]; b_8 = b[7:0] + 8'd5; end
    else     begin vi_64 = 0; sm_64 = ~sm; a_64 = ~a; b_64 = b + 64'd5; end
  endtask

  // lat counts edges including the accept edge.
  task automatic wait_done(input bit is8, input string tag, output int lat);
    logic [63:0] q, r;
    logic [3:0]  fl;
    lat = 1;
    peek(is8, q, r, fl);
    while (!fl[2] && lat < 300) begin
      @(posedge clk); #1;
      lat++;
      peek(is8, q, r, fl);
    end
    if (!fl[2]) chk({tag, " timeout"}, 64'd0, 64'd1);
  endtask

  task automatic consume(input bit is8, input string tag);
    logic [63:0] q, r;
    logic [3:0]  fl;
    @(negedge clk);
    if (is8) ro_8 = 1; else ro_64 = 1;
    @(posedge clk); #1;
    if (is8) ro_8 = 0; else ro_64 = 0;
    peek(is8, q, r, fl);
    chk({tag, " drained"}, {60'b0, fl[3:2]}, 64'b10);
  endtask

  task automatic run(input bit is8, input bit sm, input logic [63:0] a, input logic [63:0] b,
                     input logic [63:0] eq, input logic [63:0] er, input logic edz,
                     input logic eov, input int elat, input string tag);
    logic [63:0] q, r;
    logic [3:0]  fl;
    int lat;
    start(is8, sm, a, b, tag);
    wait_done(is8, tag, lat);
    peek(is8, q, r, fl);
    chk({tag, " quotient"}, q, eq);
    chk({tag, " remainder"}, r, er);
    chk({tag, " flags"}, {62'b0, fl[1:0]}, {62'b0, edz, eov});
    chk({tag, " latency"}, 64'(lat), 64'(elat));
    consume(is8, tag);
  endtask

  initial begin
    logic [63:0] q, r;
    logic [3:0]  fl;
    int lat;
    bit seen;

    repeat (3) @(posedge clk);
    #1;
    peek(0, q, r, fl);
    chk("rst64 outputs", {q, r} == 128'd0 ? 64'd0 : 64'd1, 64'd0);
    chk("rst64 flags", {60'b0, fl}, 64'b1000);
    peek(1, q, r, fl);
    chk("rst8 outputs", q | r, 64'd0);
    chk("rst8 flags", {60'b0, fl}, 64'b1000);
    rst = 0;

    run(0, 0, 64'd18, 64'd3, 64'd6, 64'd0, 0, 0, 67, "u64 18/3");
    run(0, 1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
        64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 67, "s64 -7/2");
    run(0, 1, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE,
        64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 0, 0, 67, "s64 7/-2");
    run(0, 1, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFFE,
        64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 67, "s64 -7/-2");

    run(1, 1, 64'h80, 64'hFF, 64'h80, 64'h00, 0, 1, 3,  "s8 min/-1");
    run(1, 0, 64'h80, 64'hFF, 64'h00, 64'h80, 0, 0, 11, "u8 80/ff");
    run(1, 0, 64'h5A, 64'h00, 64'hFF, 64'h5A, 1, 0, 3,  "u8 div0");
    run(1, 1, 64'h5A, 64'h00, 64'hFF, 64'h5A, 1, 0, 3,  "s8 div0");
    run(1, 1, 64'h80, 64'h02, 64'hC0, 64'h00, 0, 0, 11, "s8 -128/2");

    // Backpressure: 200/7 = 28 r 4 held for 10 cycles.
    start(1, 0, 64'd200, 64'd7, "bp");
    wait_done(1, "bp", lat);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      peek(1, q, r, fl);
      chk("bp quotient", q, 64'd28);
      chk("bp remainder", r, 64'd4);
      chk("bp ready/valid", {60'b0, fl}, 64'b0100);
    end
    consume(1, "bp");
    run(1, 1, 64'h9C, 64'h09, 64'hF5, 64'hFF, 0, 0, 11, "b2b -100/9");

    // Reset during CALC iteration 20, then a clean operation.
    start(0, 0, 64'd1000, 64'd7, "rst-mid");
    repeat (21) @(posedge clk);
    #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    peek(0, q, r, fl);
    chk("rst-mid after reset", {60'b0, fl}, 64'b1000);
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (vo_64) seen = 1;
    end
    chk("rst-mid no valid_out", {63'b0, seen}, 64'd0);
    run(0, 0, 64'd1000, 64'd7, 64'd142, 64'd6, 0, 0, 67, "post-rst 1000/7");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 64, meaning operand/result width; legal range 4..64.
REQ-002 SHALL have clk  input  1  rising-edge clock; the block uses one clock.
REQ-003 SHALL have rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have valid_in  input  1  request valid.
REQ-005 SHALL have ready_in  output  1  block can accept a request.
REQ-006 SHALL have signed_mode  input  1  1 = two's-complement operands, 0 = unsigned.
REQ-007 SHALL have dividend  input  WIDTH  numerator.
REQ-008 SHALL have divisor  input  WIDTH  denominator.
REQ-009 SHALL have quotient  output  WIDTH  result quotient.
REQ-010 SHALL have remainder  output  WIDTH  result remainder.
REQ-011 SHALL have div_by_zero  output  1  divisor was zero.
REQ-012 SHALL have overflow  output  1  signed MIN / -1 occurred.
REQ-013 SHALL have valid_out  output  1  results valid.
REQ-014 SHALL have ready_out  input  1  consumer accepts results.

Function
REQ-015 SHALL accept a request on a rising edge where valid_in && ready_in, latching dividend, divisor and signed_mode; ready_in SHALL be high only in IDLE.
REQ-016 SHALL implement states IDLE, NEG, CALC, FIX, DONE: IDLE->NEG on accept; NEG->CALC, or NEG->FIX for the special cases; CALC stays WIDTH cycles, then goes to FIX; FIX->DONE; DONE->IDLE when ready_out is high.
REQ-017 NEG SHALL form the absolute values of the operands when signed_mode is set, record q_neg = sign(dividend) XOR sign(divisor) and r_neg = sign(dividend), and detect the special cases.
REQ-018 CALC SHALL perform one restoring shift-subtract step per cycle on a (WIDTH+1)-bit partial remainder, driven by an iteration counter of $clog2(WIDTH+1) bits that counts 0..WIDTH-1.
REQ-019 FIX SHALL negate the quotient if q_neg is set and negate the remainder if r_neg is set, giving truncation toward zero with the remainder taking the dividend's sign.
REQ-020 Division by zero SHALL return quotient = all ones, remainder = the original dividend, and div_by_zero = 1, in both modes.
REQ-021 Signed overflow (dividend = 1 followed by WIDTH-1 zeros, divisor = all ones, signed_mode = 1) SHALL return quotient = dividend, remainder = 0, and overflow = 1.
REQ-022 Normal latency SHALL be WIDTH+3 cycles from the accept edge to valid_out high; special-case latency SHALL be 3 cycles.
REQ-023 valid_out SHALL be high only in DONE; quotient, remainder and flags SHALL stay stable while valid_out && !ready_out (backpressure).
REQ-024 A result SHALL be consumed on the edge where valid_out && ready_out; ready_in SHALL rise in the following cycle, so there is no same-cycle accept-on-drain.
REQ-025 valid_in SHALL be ignored in every state except IDLE, and operand changes after accept SHALL NOT affect the result.

Reset
REQ-026 rst high on a rising edge SHALL force state IDLE, counter 0, and valid_out, div_by_zero and overflow to 0; quotient and remainder SHALL reset to 0.
REQ-027 rst asserted mid-operation, in any state, SHALL abandon the operation with no valid_out pulse; ready_in SHALL be 1 in the first cycle after reset.
REQ-028 rst SHALL take priority over simultaneous valid_in and ready_out.

Structure
REQ-029 A shared package div_pkg SHALL hold the state enum (div_state_t) and the latency constants DIV_FIX_CYCLES = 3 and DIV_LAT(W) = W+3.
REQ-030 The combinational one-step subtract/shift SHALL be a sub-module div_step, parameterised by WIDTH.
REQ-031 Operand, remainder and quotient registers SHALL be enable-gated, loaded only by the FSM.

Verification
REQ-032 WIDTH=64, unsigned, 18/3 -> quotient 6, remainder 0, valid_out at cycle 67 after accept, flags 0.
REQ-033 WIDTH=64, signed, -7/2 -> quotient -3, remainder -1; 7/-2 -> quotient -3, remainder 1; -7/-2 -> quotient 3, remainder -1.
REQ-034 WIDTH=8, signed, 0x80/0xFF -> quotient 0x80, remainder 0x00, overflow 1, latency 3; unsigned 0x80/0xFF -> quotient 0, remainder 0x80.
REQ-035 WIDTH=8, divisor 0, dividend 0x5A -> quotient 0xFF, remainder 0x5A, div_by_zero 1, in both modes.
REQ-036 Hold ready_out=0 for 10 cycles in DONE -> outputs stable and ready_in=0 throughout; pulse ready_out -> IDLE next cycle, and a back-to-back request is accepted.
REQ-037 Assert rst during CALC iteration 20 -> no valid_out, ready_in=1 after reset, and the next request returns a correct result.
